// File: rtl/frame_stats_pkg.sv
// frame_stats shared types: FSM states, width helpers, result bundle.
// Optional energy path is enabled by macro FRAME_STATS_ENERGY_EN.
package frame_stats_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    DONE
  } state_e;

  function automatic int sum_w(input int w, input int d);
    return w + $clog2(d);
  endfunction

  function automatic int energy_w(input int w, input int d);
    return 2 * w + $clog2(d);
  endfunction

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);
  localparam int DEF_SW    = sum_w(DEF_WIDTH, DEF_DEPTH);
  localparam int DEF_EW    = energy_w(DEF_WIDTH, DEF_DEPTH);

  typedef struct packed {
    logic        [DEF_WIDTH-1:0] peak;
    logic        [DEF_AW-1:0]    peak_idx;
    logic signed [DEF_SW-1:0]    sum;
    logic        [DEF_EW-1:0]    energy;
  } stats_t;

endpackage

// File: rtl/frame_stats_if.sv
// frame_stats bus: upstream buffer read side plus stats result side.
// Signal names match the block's port list; FRAME_STATS_ENERGY_EN gates energy.
interface frame_stats_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = frame_stats_pkg::sum_w(WIDTH, DEPTH);
  localparam int EW = frame_stats_pkg::energy_w(WIDTH, DEPTH);

  logic [WIDTH-1:0] read_data_i;
  logic             read_enable_i;
  logic             buffer_ready_i;
  logic             read_ack_o;
  logic             stats_valid_o;
  logic             stats_ready_i;
  logic [WIDTH-1:0] peak_o;
  logic [AW-1:0]    peak_idx_o;
  logic [SW-1:0]    sum_o;
  logic [EW-1:0]    energy_o;
  logic             frame_abort_o;

  modport slave (
    input  read_data_i,
    input  read_enable_i,
    input  buffer_ready_i,
    input  stats_ready_i,
    output read_ack_o,
    output stats_valid_o,
    output peak_o,
    output peak_idx_o,
    output sum_o,
    output energy_o,
    output frame_abort_o
  );

  modport master (
    output read_data_i,
    output read_enable_i,
    output buffer_ready_i,
    output stats_ready_i,
    input  read_ack_o,
    input  stats_valid_o,
    input  peak_o,
    input  peak_idx_o,
    input  sum_o,
    input  energy_o,
    input  frame_abort_o
  );

endinterface

// File: rtl/frame_stats_acc.sv
// frame_stats datapath: exact |x|, first-peak tracking, sum, energy.
// Squarer and energy accumulator exist only with FRAME_STATS_ENERGY_EN.
module frame_stats_acc
  import frame_stats_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = sum_w(WIDTH, DEPTH),
  localparam int EW    = energy_w(WIDTH, DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [AW-1:0]    idx_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] peak_o,
  output logic [AW-1:0]    peak_idx_o,
  output logic [SW-1:0]    sum_o,
  output logic [EW-1:0]    energy_o
);

  logic signed [WIDTH:0] ext;
  logic        [WIDTH:0] mag;
  logic        [SW-1:0]  sext;

  // one extra bit keeps |-2^(WIDTH-1)| exact
  always_comb begin
    ext  = {sample_i[WIDTH-1], sample_i};
    mag  = ext[WIDTH] ? -ext : ext;
    sext = {{(SW-WIDTH){sample_i[WIDTH-1]}}, sample_i};
  end

  // peak only moves on strictly larger magnitude; sum never saturates
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_o     <= '0;
      peak_idx_o <= '0;
      sum_o      <= '0;
    end else if (clr_i) begin
      peak_o     <= '0;
      peak_idx_o <= '0;
      sum_o      <= '0;
    end else if (en_i) begin
      if (mag > {1'b0, peak_o}) begin
        peak_o     <= mag[WIDTH-1:0];
        peak_idx_o <= idx_i;
      end
      sum_o <= sum_o + sext;
    end
  end

`ifdef FRAME_STATS_ENERGY_EN
  logic signed [2*WIDTH-1:0] sq;

  assign sq = $signed(sample_i) * $signed(sample_i);

  // energy follows exactly the same clear/enable timing as sum
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      energy_o <= '0;
    end else if (clr_i) begin
      energy_o <= '0;
    end else if (en_i) begin
      energy_o <= energy_o + {{(EW-2*WIDTH){1'b0}}, sq};
    end
  end
`else
  assign energy_o = '0;
`endif

endmodule

// File: rtl/frame_stats.sv
// frame_stats top: reset sync, frame FSM, wait counter, handshakes.
// Energy output is live only when FRAME_STATS_ENERGY_EN is defined.
module frame_stats
  import frame_stats_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  frame_stats_if.slave  bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = $clog2(RD_LAT + 1);

  state_e          state_q;
  logic [WCW-1:0]  wcnt_q;
  logic [AW-1:0]   idx_q;
  logic            valid_q;
  logic            abort_q;
  logic [1:0]      rst_sync_q;
  logic            run;
  logic            start;
  logic            ack;

  // release of reset reaches the FSM only after two clocks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run   = rst_sync_q[1];
  assign start = bus.buffer_ready_i & run;
  assign ack   = (state_q == CAPTURE) & bus.read_enable_i & ~start;

  assign bus.read_ack_o    = ack;
  assign bus.stats_valid_o = valid_q;
  assign bus.frame_abort_o = abort_q;

  // frame sequencing; a new buffer always restarts, aborting live work
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (start) begin
        state_q <= WAIT;
        wcnt_q  <= WCW'(RD_LAT);
        idx_q   <= '0;
        valid_q <= 1'b0;
        abort_q <= (state_q != IDLE);
      end else begin
        unique case (state_q)
          IDLE: begin
          end
          WAIT: begin
            if (wcnt_q <= WCW'(1)) begin
              state_q <= CAPTURE;
            end else begin
              wcnt_q <= wcnt_q - WCW'(1);
            end
          end
          CAPTURE: begin
            if (bus.read_enable_i) begin
              idx_q <= idx_q + AW'(1);
              if (idx_q == AW'(DEPTH - 1)) begin
                state_q <= DONE;
                valid_q <= 1'b1;
              end else begin
                state_q <= WAIT;
                wcnt_q  <= WCW'(RD_LAT);
              end
            end else begin
              state_q <= IDLE;
              abort_q <= 1'b1;
            end
          end
          DONE: begin
            if (bus.stats_ready_i) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  frame_stats_acc #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_acc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (start),
    .en_i       (ack),
    .idx_i      (idx_q),
    .sample_i   (bus.read_data_i),
    .peak_o     (bus.peak_o),
    .peak_idx_o (bus.peak_idx_o),
    .sum_o      (bus.sum_o),
    .energy_o   (bus.energy_o)
  );

endmodule

// File: tb/tb_frame_stats.sv
// frame_stats bench: ping-pong upstream with 2-cycle read latency.
// Energy expectations follow FRAME_STATS_ENERGY_EN.
module tb_frame_stats;
  import frame_stats_pkg::*;

  localparam int W  = 16;
  localparam int D  = 256;
  localparam int RL = 2;
  localparam int SWB = sum_w(W, D);
  localparam int EWB = energy_w(W, D);

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk = ~clk;

  frame_stats_if #(.WIDTH(W), .DEPTH(D)) bus ();

  frame_stats #(
    .WIDTH  (W),
    .DEPTH  (D),
    .RD_LAT (RL)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  logic signed [W-1:0] bank [2][D];
  int fill_bank = 0;
  int rd_bank = 0;
  int ptr = 0;
  logic [W-1:0] p1, p2;

  // upstream buffer: address moves on ack, data arrives 2 clocks later
  always @(posedge clk) begin
    if (bus.buffer_ready_i) begin
      rd_bank <= fill_bank;
      ptr <= 0;
    end else if (bus.read_ack_o) begin
      ptr <= ptr + 1;
    end
    p1 <= bank[rd_bank][ptr % D];
    p2 <= p1;
  end

  assign bus.read_data_i = p2;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;
  int fb = 0;
  int n;
  stats_t exp_s;
  logic [63:0] s_pk, s_ix, s_sm, s_en;
  bit stable;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (bus.read_ack_o === 1'b1) ack_cnt++;
  endtask

  // reference: plain arithmetic over the frame as the spec defines it
  task automatic model(input int b);
    longint pk, pi, sm, en, v, a;
    pk = 0; pi = 0; sm = 0; en = 0;
    for (int i = 0; i < D; i++) begin
      v = longint'(bank[b][i]);
      a = (v < 0) ? -v : v;
      if (a > pk) begin
        pk = a;
        pi = i;
      end
      sm += v;
      en += v * v;
    end
`ifndef FRAME_STATS_ENERGY_EN
    en = 0;
`endif
    exp_s.peak     = W'(pk);
    exp_s.peak_idx = DEF_AW'(pi);
    exp_s.sum      = SWB'(sm);
    exp_s.energy   = EWB'(en);
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < D; i++) begin
      case (kind)
        0: bank[fb][i] = W'(i);
        1: bank[fb][i] = -16'sd32768;
        2: bank[fb][i] = '0;
        default: bank[fb][i] = W'($urandom);
      endcase
    end
    if (kind == 2) begin
      bank[fb][0] = 16'sd100;
      bank[fb][5] = -16'sd300;
      bank[fb][9] = 16'sd300;
    end
  endtask

  task automatic pulse();
    fill_bank = fb;
    bus.buffer_ready_i = 1'b1;
    ack_cnt = 0;
    tick();
    bus.buffer_ready_i = 1'b0;
    fb ^= 1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.stats_valid_o !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("valid_seen", 64'(bus.stats_valid_o), 64'(1));
  endtask

  task automatic check_stats(input string tag, input int b);
    model(b);
    chk({tag, "_peak"}, 64'(bus.peak_o), 64'(exp_s.peak));
    chk({tag, "_idx"}, 64'(bus.peak_idx_o), 64'(exp_s.peak_idx));
    chk({tag, "_sum"}, 64'($signed(bus.sum_o)),
        64'($signed(exp_s.sum)));
    chk({tag, "_energy"}, 64'(bus.energy_o), 64'(exp_s.energy));
  endtask

  task automatic run_full(input string tag, input int kind);
    int b;
    b = fb;
    fill(kind);
    pulse();
    wait_valid(n);
    chk({tag, "_latency"}, 64'(n), 64'(D * (RL + 1)));
    check_stats(tag, b);
    chk({tag, "_acks"}, 64'(ack_cnt), 64'(D));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.stats_valid_o), 64'(0));
    chk({tag, "_ack"}, 64'(bus.read_ack_o), 64'(0));
    chk({tag, "_abort"}, 64'(bus.frame_abort_o), 64'(0));
    chk({tag, "_peak"}, 64'(bus.peak_o), 64'(0));
    chk({tag, "_idx"}, 64'(bus.peak_idx_o), 64'(0));
    chk({tag, "_sum"}, 64'(bus.sum_o), 64'(0));
    chk({tag, "_energy"}, 64'(bus.energy_o), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.buffer_ready_i = 1'b0;
    bus.read_enable_i  = 1'b1;
    bus.stats_ready_i  = 1'b1;
    rst_ni = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_ni = 1'b1;
    repeat (5) tick();

    // ramp, consumer always ready
    run_full("ramp", 0);
    tick();
    chk("ramp_idle", 64'(bus.stats_valid_o), 64'(0));

    // most negative value everywhere
    run_full("minval", 1);
    tick();

    // sparse frame with tied magnitudes
    run_full("sparse", 2);
    tick();

    // consumer stalls 50 cycles in DONE
    bus.stats_ready_i = 1'b0;
    run_full("stall", 3);
    s_pk = 64'(bus.peak_o);
    s_ix = 64'(bus.peak_idx_o);
    s_sm = 64'(bus.sum_o);
    s_en = 64'(bus.energy_o);
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (bus.stats_valid_o !== 1'b1 ||
          64'(bus.peak_o) !== s_pk ||
          64'(bus.peak_idx_o) !== s_ix ||
          64'(bus.sum_o) !== s_sm ||
          64'(bus.energy_o) !== s_en)
        stable = 1'b0;
    end
    chk("stall_stable", 64'(stable), 64'(1));
    chk("stall_acks", 64'(ack_cnt), 64'(D));
    bus.stats_ready_i = 1'b1;
    tick();
    chk("stall_release", 64'(bus.stats_valid_o), 64'(0));
    repeat (3) tick();
    chk("stall_idle_acks", 64'(ack_cnt), 64'(D));

    // restart mid-frame at sample 100
    fill(3);
    pulse();
    n = 0;
    while (ack_cnt < 100 && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_reach100", 64'(ack_cnt), 64'(100));
    tick();
    n = fb;
    fill(3);
    pulse();
    chk("abort_pulse", 64'(bus.frame_abort_o), 64'(1));
    chk("abort_ackcnt", 64'(ack_cnt), 64'(0));
    tick();
    chk("abort_single", 64'(bus.frame_abort_o), 64'(0));
    wait_valid(n);
    chk("abort_latency", 64'(n), 64'(D * (RL + 1) - 1));
    check_stats("abort_new", fb ^ 1);
    chk("abort_acks", 64'(ack_cnt), 64'(D));
    tick();

    // reset while waiting on sample 40
    fill(3);
    pulse();
    n = 0;
    while (ack_cnt < 40 && n < 1000) begin
      tick();
      n++;
    end
    chk("rst_reach40", 64'(ack_cnt), 64'(40));
    tick();
    rst_ni = 1'b0;
    #1;
    check_zero("midrst");
    repeat (3) tick();
    rst_ni = 1'b1;
    ack_cnt = 0;
    repeat (10) tick();
    chk("midrst_noack", 64'(ack_cnt), 64'(0));
    chk("midrst_novalid", 64'(bus.stats_valid_o), 64'(0));
    run_full("postrst", 3);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
